instr_fetch_unit: RTL
=====================

Name: instr_fetch_unit

Overview:
- Front end of the single-cycle core. Generates sequential PCs and issues word reads to instruction memory over a request/grant/rvalid interface.
- Buffers returned instruction words in a small in-order FIFO and presents them with a valid/ready handshake.
- Supplies instr_o and op_code_o to the opcode decoder/controller.
- Handles control-flow redirects by flushing the FIFO and discarding stale in-flight responses.

Parameters:
- XLEN, 32, address/data width.
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- DEPTH, 2, FIFO entries, which is also the maximum outstanding requests. Power of two, at least 2.

Ports:
- clk_i  input  1  clock, rising edge.
- rst_i  input  1  reset, synchronous, active-high.
- imem_req_o  output  1  read request valid.
- imem_addr_o  output  XLEN  word-aligned read address (bits [1:0] = 0).
- imem_gnt_i  input  1  memory accepts the request this cycle (handshake = req & gnt).
- imem_rvalid_i  input  1  read data valid; responses return in order, at least 1 cycle after grant.
- imem_rdata_i  input  XLEN  instruction word.
- redirect_i  input  1  branch/jump taken; restart fetch at redirect_pc_i.
- redirect_pc_i  input  XLEN  target; bits [1:0] are ignored and forced to 0.
- instr_valid_o  output  1  FIFO head valid.
- instr_ready_i  input  1  consumer accepts the head (handshake = valid & ready).
- instr_o  output  XLEN  head instruction word.
- instr_pc_o  output  XLEN  PC of the head instruction.
- op_code_o  output  7  instr_o[6:0].

Behaviour:
- Reset (rst_i=1 at clock edge):
  - pc_q=RESET_PC; FIFO empty; outstanding=0; discard=0; state=FETCH.
  - imem_req_o=0, instr_valid_o=0, instr_o=0, instr_pc_o=0, op_code_o=0.
  - Reset mid-transaction abandons all in-flight requests. Responses arriving after reset release are NOT dropped by design; the system resets memory concurrently.
- Issue rule: imem_req_o=1 when state==FETCH, !redirect_i, and (outstanding + fifo_count) < DEPTH. imem_addr_o=pc_q.
- On req&gnt: pc_q += 4 with XLEN wrap (32'hFFFF_FFFC -> 0, no flag); outstanding += 1. A PC tag FIFO records the issued address.
- On rvalid with discard==0: push {rdata, tagged pc}; outstanding -= 1. The credit rule guarantees no overflow. If rvalid arrives with the FIFO full, that is a protocol error: assert, and drop the data.
- Pop on instr_valid_o & instr_ready_i. Push and pop in the same cycle are allowed, including when the FIFO is full: the pop frees the slot and the push is accepted. Head data is registered FIFO storage; there is no combinational path from imem_rdata_i to instr_o. Minimum latency is grant cycle +1 (rvalid) +1 (valid_o).
- An outstanding increment and decrement in the same cycle net to zero.
- States:
  - FETCH: normal operation.
  - FLUSH: waiting for stale responses; no requests are issued.
- Redirect (redirect_i=1, any state, highest priority):
  - FIFO cleared (instr_valid_o=0 next cycle); a pop in that cycle is ignored.
  - pc_q=redirect_pc_i & ~3.
  - discard = outstanding + (req&gnt this cycle ? 1 : 0) - (rvalid this cycle ? 1 : 0). The grant is counted even though req is forced low; this covers gnt glitches and must be handled.
  - Next state = FLUSH if discard>0, else FETCH. outstanding is set to the same value as discard.
- FLUSH: each rvalid decrements discard and outstanding, and its data is dropped. When discard reaches 0, go to FETCH; the first request is issued the following cycle. A redirect during FLUSH recomputes per the rule above and updates pc_q.
- op_code_o is always instr_o[6:0].
- instr_o/instr_pc_o are held stable while valid & !ready.

Test Plan:
- Reset RESET_PC=0, gnt=1 always, rdata=PC-derived, rvalid 1 cycle after grant, ready=1 → addresses 0,4,8,...; first instr_valid_o 2 cycles after reset release; instr_pc_o=0,4,8 in order; op_code_o=rdata[6:0].
- Backpressure: ready=0 for 10 cycles → exactly DEPTH(2) requests issued, then imem_req_o=0; FIFO holds PC 0 and 4 stable; ready=1 → drains 0,4 then resumes at 8 with no gaps or duplicates.
- Redirect with 2 outstanding (rvalid delayed 3 cycles), redirect_pc=32'h0000_0103 → next addr 32'h0000_0100; both stale responses dropped; no request during FLUSH; first valid output has instr_pc_o=32'h100.
- Redirect in the same cycle as rvalid and req&gnt → discard count is correct; no stale word appears at the output; FIFO is empty the next cycle.
- PC wrap: RESET_PC=32'hFFFF_FFF8 → addresses FFFF_FFF8, FFFF_FFFC, 0000_0000, 0000_0004.
- Reset asserted with 2 outstanding and FIFO full → all outputs 0 next cycle; the fetch restarts at RESET_PC.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// Instruction fetch front end: sequential PC generation, credit-limited word reads,
// an in-order instruction FIFO with PC tags, and redirect flushing of stale responses.
module instr_fetch_unit #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int              DEPTH    = 2
) (
  input  logic            clk_i,
  input  logic            rst_i,
  output logic            imem_req_o,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic            imem_gnt_i,
  input  logic            imem_rvalid_i,
  input  logic [XLEN-1:0] imem_rdata_i,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  output logic            instr_valid_o,
  input  logic            instr_ready_i,
  output logic [XLEN-1:0] instr_o,
  output logic [XLEN-1:0] instr_pc_o,
  output logic [6:0]      op_code_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 2;
  localparam logic [AW:0]   FIFO_FULL = (AW+1)'(DEPTH);
  localparam logic [CW-1:0] CREDITS   = CW'(DEPTH);
  localparam logic [0:0]    ST_FETCH  = 1'b0;
  localparam logic [0:0]    ST_FLUSH  = 1'b1;

  logic [XLEN-1:0] r_pc;
  logic [0:0]      r_state;
  logic [CW-1:0]   r_outstanding;
  logic [CW-1:0]   r_discard;
  logic [AW:0]     r_count;
  logic [AW-1:0]   r_rdPtr;
  logic [AW-1:0]   r_wrPtr;
  logic [AW-1:0]   r_tagRdPtr;
  logic [AW-1:0]   r_tagWrPtr;
  logic [XLEN-1:0] r_instrMem [DEPTH];
  logic [XLEN-1:0] r_pcMem    [DEPTH];
  logic [XLEN-1:0] r_tagMem   [DEPTH];

  logic [CW-1:0]   w_inflight;
  logic [CW-1:0]   w_redirectCount;
  logic [XLEN-1:0] w_redirectPc;
  logic            w_issue;
  logic            w_fire;
  logic            w_valid;
  logic            w_full;
  logic            w_keepRsp;
  logic            w_pop;
  logic            w_push;
  logic            w_dec;

  // Requests in flight plus buffered words may never exceed the FIFO depth.
  assign w_inflight      = r_outstanding + CW'(r_count);
  assign w_issue         = !rst_i && (r_state == ST_FETCH) && !redirect_i && (w_inflight < CREDITS);
  assign w_fire          = w_issue && imem_gnt_i;
  assign w_valid         = (r_count != '0);
  assign w_full          = (r_count == FIFO_FULL);
  assign w_keepRsp       = imem_rvalid_i && !redirect_i && (r_discard == '0);
  assign w_pop           = w_valid && instr_ready_i && !redirect_i;
  assign w_push          = w_keepRsp && (!w_full || w_pop);
  assign w_dec           = imem_rvalid_i && (r_outstanding != '0);
  // A grant seen during a redirect is counted so its eventual response gets discarded.
  assign w_redirectCount = r_outstanding + CW'(imem_gnt_i) - CW'(w_dec);
  assign w_redirectPc    = redirect_pc_i & ~XLEN'(3);

  assign imem_req_o    = w_issue;
  assign imem_addr_o   = r_pc;
  assign instr_valid_o = w_valid;
  assign instr_o       = w_valid ? r_instrMem[r_rdPtr] : '0;
  assign instr_pc_o    = w_valid ? r_pcMem[r_rdPtr] : '0;
  assign op_code_o     = instr_o[6:0];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_pc          <= RESET_PC;
      r_state       <= ST_FETCH;
      r_outstanding <= '0;
      r_discard     <= '0;
      r_count       <= '0;
      r_rdPtr       <= '0;
      r_wrPtr       <= '0;
      r_tagRdPtr    <= '0;
      r_tagWrPtr    <= '0;
    end else if (redirect_i) begin
      r_pc          <= w_redirectPc;
      r_outstanding <= w_redirectCount;
      r_discard     <= w_redirectCount;
      r_state       <= (w_redirectCount != '0) ? ST_FLUSH : ST_FETCH;
      r_count       <= '0;
      r_rdPtr       <= '0;
      r_wrPtr       <= '0;
      r_tagRdPtr    <= '0;
      r_tagWrPtr    <= '0;
    end else begin
      if (w_fire) begin
        r_pc       <= r_pc + XLEN'(4);
        r_tagWrPtr <= r_tagWrPtr + AW'(1);
      end
      r_outstanding <= r_outstanding + CW'(w_fire) - CW'(w_dec);
      // Stale responses are dropped; the last one returns the unit to fetching.
      if ((r_state == ST_FLUSH) && imem_rvalid_i) begin
        r_discard <= r_discard - CW'(1);
        if (r_discard == CW'(1)) begin
          r_state <= ST_FETCH;
        end
      end
      if (w_keepRsp) begin
        r_tagRdPtr <= r_tagRdPtr + AW'(1);
      end
      if (w_push) begin
        r_wrPtr <= r_wrPtr + AW'(1);
      end
      if (w_pop) begin
        r_rdPtr <= r_rdPtr + AW'(1);
      end
      r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_fire) begin
      r_tagMem[r_tagWrPtr] <= r_pc;
    end
    if (w_push && !rst_i) begin
      r_instrMem[r_wrPtr] <= imem_rdata_i;
      r_pcMem[r_wrPtr]    <= r_tagMem[r_tagRdPtr];
    end
  end

  // A response landing in a full FIFO with no pop means the memory broke the credit contract.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      assert (!(w_keepRsp && w_full && !w_pop));
    end
  end

endmodule
